// File: rtl/dec_pkg.sv
// Shared types and constants for the one-hot decoder / scan sequencer.
package dec_pkg;

    localparam int   ERR_CNT_W = 8;
    // Out-of-range decodes drive every output bit to this value.
    localparam logic ERR_FILL  = 1'b1;

    typedef enum logic [1:0] {
        DIS    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        SWITCH = 2'd3
    } stateE;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } modeE;

    function automatic logic [ERR_CNT_W-1:0] satInc(input logic [ERR_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Scan step divider: pulses oTICK on the last of every SCAN_DIV running cycles.
module scan_tick #(
    parameter int SCAN_DIV = 4
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iCLR_DIV,
    input  logic iRUN,
    output logic oTICK
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] divCnt;

    assign oTICK = iRUN && (divCnt == DIV_LAST);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            divCnt <= '0;
        end else if (iCLR_DIV) begin
            divCnt <= '0;
        end else if (iRUN) begin
            divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Index-to-one-hot decoder with a free-running scan mode and an error counter.
//
// state  | meaning
// DIS    | disabled: outputs blanked, scan index and divider held at 0
// DIRECT | decode iIN on each iVALID transfer
// SCAN   | step a single hot bit through all outputs every SCAN_DIV cycles
// SWITCH | one blank cycle between DIRECT and SCAN
module dec_scan
    import dec_pkg::*;
#(
    parameter int N_OUT    = 10,
    parameter int W_IN     = $clog2(N_OUT),
    parameter int SCAN_DIV = 4
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iEN,
    input  logic                 iMODE,
    input  logic                 iVALID,
    input  logic [W_IN-1:0]      iIN,
    input  logic                 iCLR,
    output logic                 oREADY,
    output logic [N_OUT-1:0]     oOUT,
    output logic                 oVALID,
    output logic                 oERR,
    output logic [W_IN-1:0]      oIDX,
    output logic [ERR_CNT_W-1:0] oERR_CNT
);

    localparam logic [N_OUT-1:0] ONE_LSB  = N_OUT'(1);
    localparam logic [W_IN-1:0]  IDX_LAST = W_IN'(N_OUT - 1);

    stateE           state;
    stateE           nextState;
    modeE            modeReg;
    modeE            reqMode;
    logic [W_IN-1:0] scanIdx;
    logic            tick;
    logic            xfer;
    logic            inRange;
    logic            scanStep;
    logic            blank;

    assign reqMode = modeE'(iMODE);

    always_comb begin
        nextState = state;
        if (!iEN) begin
            nextState = DIS;
        end else begin
            case (state)
                DIS, SWITCH:  nextState = (reqMode == MODE_SCAN) ? SCAN : DIRECT;
                DIRECT, SCAN: if (reqMode != modeReg) nextState = SWITCH;
                default:      nextState = DIS;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state   <= DIS;
            modeReg <= MODE_DIRECT;
        end else begin
            state <= nextState;
            if (nextState == SCAN)   modeReg <= MODE_SCAN;
            if (nextState == DIRECT) modeReg <= MODE_DIRECT;
        end
    end

    // Not ready on the cycle we leave DIRECT, so a sample is never accepted and then blanked.
    assign oREADY   = (state == DIRECT) && (nextState == DIRECT);
    assign xfer     = oREADY && iVALID;
    assign inRange  = 32'(iIN) < 32'(N_OUT);
    assign scanStep = tick && (nextState == SCAN);
    assign blank    = (nextState == DIS) || (nextState == SWITCH);

    scan_tick #(.SCAN_DIV(SCAN_DIV)) uScanTick (
        .iCLK     (iCLK),
        .iRSTn    (iRSTn),
        .iCLR_DIV (state != SCAN),
        .iRUN     (state == SCAN),
        .oTICK    (tick)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oOUT    <= '0;
            oVALID  <= 1'b0;
            oERR    <= 1'b0;
            oIDX    <= '0;
            scanIdx <= '0;
        end else begin
            oVALID <= 1'b0;
            if (blank) begin
                oOUT    <= '0;
                oERR    <= 1'b0;
                scanIdx <= '0;
            end else if (xfer) begin
                oOUT   <= inRange ? (ONE_LSB << iIN) : {N_OUT{ERR_FILL}};
                oERR   <= !inRange;
                oIDX   <= iIN;
                oVALID <= 1'b1;
            end else if (scanStep) begin
                oOUT    <= ONE_LSB << scanIdx;
                oERR    <= 1'b0;
                oIDX    <= scanIdx;
                oVALID  <= 1'b1;
                scanIdx <= (scanIdx == IDX_LAST) ? '0 : scanIdx + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oERR_CNT <= '0;
        end else if (iCLR) begin
            oERR_CNT <= '0;
        end else if (xfer && !inRange) begin
            oERR_CNT <= satInc(oERR_CNT);
        end
    end

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan (N_OUT=10, SCAN_DIV=4): vector table plus scoreboard of expected pulses.
module tb_dec_scan;

    logic       iCLK = 1'b0;
    logic       iRSTn;
    logic       iEN;
    logic       iMODE;
    logic       iVALID;
    logic [3:0] iIN;
    logic       iCLR;
    logic       oREADY;
    logic [9:0] oOUT;
    logic       oVALID;
    logic       oERR;
    logic [3:0] oIDX;
    logic [7:0] oERR_CNT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [9:0] out;
        logic [3:0] idx;
        logic       err;
    } sbEntry;
    sbEntry sb[$];

    typedef struct {
        logic [3:0] idx;
        logic [9:0] expOut;
        logic       expErr;
    } vecT;
    vecT vec[12];

    dec_scan #(.N_OUT(10), .SCAN_DIV(4)) dut (
        .iCLK     (iCLK),
        .iRSTn    (iRSTn),
        .iEN      (iEN),
        .iMODE    (iMODE),
        .iVALID   (iVALID),
        .iIN      (iIN),
        .iCLR     (iCLR),
        .oREADY   (oREADY),
        .oOUT     (oOUT),
        .oVALID   (oVALID),
        .oERR     (oERR),
        .oIDX     (oIDX),
        .oERR_CNT (oERR_CNT)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [9:0] o, input logic [3:0] ix, input logic e);
        sbEntry s;
        s.cyc = c; s.out = o; s.idx = ix; s.err = e;
        sb.push_back(s);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Scoreboard: every oVALID pulse must match the oldest expected entry, including its cycle.
    always @(negedge iCLK) begin
        if (iRSTn) begin
            if (oVALID) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got oVALID with oOUT=%0h expected no pulse (cycle %0d)", oOUT, cyc);
                end else begin
                    sbEntry e;
                    e = sb.pop_front();
                    chk("sb_cycle", cyc, e.cyc);
                    chk("sb_out", {22'd0, oOUT}, {22'd0, e.out});
                    chk("sb_idx", {28'd0, oIDX}, {28'd0, e.idx});
                    chk("sb_err", {31'd0, oERR}, {31'd0, e.err});
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                sbEntry e;
                e = sb.pop_front();
                checks++; errors++;
                $display("FAIL sb_missing: got no pulse expected oOUT=%0h at cycle %0d", e.out, e.cyc);
            end
            chk("onehot_or_err", {31'd0, ($onehot0(oOUT) || (&oOUT))}, 32'd1);
        end
    end

    initial begin
        int k;
        vec[0]  = '{4'd0,  10'h001, 1'b0};
        vec[1]  = '{4'd1,  10'h002, 1'b0};
        vec[2]  = '{4'd2,  10'h004, 1'b0};
        vec[3]  = '{4'd3,  10'h008, 1'b0};
        vec[4]  = '{4'd4,  10'h010, 1'b0};
        vec[5]  = '{4'd5,  10'h020, 1'b0};
        vec[6]  = '{4'd6,  10'h040, 1'b0};
        vec[7]  = '{4'd7,  10'h080, 1'b0};
        vec[8]  = '{4'd8,  10'h100, 1'b0};
        vec[9]  = '{4'd9,  10'h200, 1'b0};
        vec[10] = '{4'd12, 10'h3FF, 1'b1};
        vec[11] = '{4'd15, 10'h3FF, 1'b1};

        iRSTn = 1'b0; iEN = 1'b0; iMODE = 1'b0; iVALID = 1'b0; iIN = '0; iCLR = 1'b0;
        repeat (3) step();
        chk("rst_out",    {22'd0, oOUT}, 32'd0);
        chk("rst_valid",  {31'd0, oVALID}, 32'd0);
        chk("rst_err",    {31'd0, oERR}, 32'd0);
        chk("rst_ready",  {31'd0, oREADY}, 32'd0);
        chk("rst_idx",    {28'd0, oIDX}, 32'd0);
        chk("rst_errcnt", {24'd0, oERR_CNT}, 32'd0);

        // Straight into DIRECT on the first enabled cycle after reset.
        iRSTn = 1'b1; iEN = 1'b1;
        step();
        chk("direct_entry_ready", {31'd0, oREADY}, 32'd1);
        chk("direct_entry_out",   {22'd0, oOUT}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            iVALID = 1'b1; iIN = vec[i].idx;
            push(cyc + 1, vec[i].expOut, vec[i].idx, vec[i].expErr);
            step();
        end
        iVALID = 1'b0;
        repeat (2) step();
        chk("sweep_errcnt",   {24'd0, oERR_CNT}, 32'd2);
        chk("hold_out",       {22'd0, oOUT}, 32'h3FF);
        chk("hold_err",       {31'd0, oERR}, 32'd1);
        chk("hold_idx",       {28'd0, oIDX}, 32'd15);

        for (int i = 0; i < 260; i++) begin
            iVALID = 1'b1; iIN = 4'd13;
            push(cyc + 1, 10'h3FF, 4'd13, 1'b1);
            step();
        end
        iVALID = 1'b0;
        step();
        chk("errcnt_saturate", {24'd0, oERR_CNT}, 32'd255);

        iVALID = 1'b1; iIN = 4'd11; iCLR = 1'b1;
        push(cyc + 1, 10'h3FF, 4'd11, 1'b1);
        step();
        iVALID = 1'b0; iCLR = 1'b0;
        chk("clr_wins", {24'd0, oERR_CNT}, 32'd0);

        iVALID = 1'b1; iIN = 4'd7;
        push(cyc + 1, 10'h080, 4'd7, 1'b0);
        step();
        chk("good_after_bad_err", {31'd0, oERR}, 32'd0);

        // Disable with a bad sample presented: nothing accepted, outputs blank, count frozen.
        iEN = 1'b0; iIN = 4'd14;
        step();
        chk("dis_out",    {22'd0, oOUT}, 32'd0);
        chk("dis_ready",  {31'd0, oREADY}, 32'd0);
        step();
        chk("dis_errcnt", {24'd0, oERR_CNT}, 32'd0);
        iEN = 1'b1; iVALID = 1'b0;
        step();
        chk("reen_ready", {31'd0, oREADY}, 32'd1);
        step();
        chk("reen_out_blank", {22'd0, oOUT}, 32'd0);

        // DIRECT -> SWITCH -> SCAN; first step lands 4 cycles after SCAN entry.
        iMODE = 1'b1;
        k = cyc;
        for (int j = 0; j < 16; j++)
            push(k + 6 + 4 * j, 10'b1 << (j % 10), 4'(j % 10), 1'b0);
        step();
        chk("switch_ready", {31'd0, oREADY}, 32'd0);
        chk("switch_out",   {22'd0, oOUT}, 32'd0);
        repeat (k + 66 - cyc) step();
        chk("scan_mid_idx", {28'd0, oIDX}, 32'd5);
        chk("scan_mid_out", {22'd0, oOUT}, 32'h020);

        iMODE = 1'b0;
        step();
        chk("switch2_out",   {22'd0, oOUT}, 32'd0);
        chk("switch2_valid", {31'd0, oVALID}, 32'd0);
        chk("switch2_ready", {31'd0, oREADY}, 32'd0);
        step();
        chk("back_direct_ready", {31'd0, oREADY}, 32'd1);
        chk("back_direct_out",   {22'd0, oOUT}, 32'd0);

        iMODE = 1'b1;
        k = cyc;
        push(k + 6,  10'h001, 4'd0, 1'b0);
        push(k + 10, 10'h002, 4'd1, 1'b0);
        repeat (k + 11 - cyc) step();
        chk("rescan_out", {22'd0, oOUT}, 32'h002);
        chk("sb_drained", sb.size(), 32'd0);

        // Asynchronous reset between edges must clear outputs immediately.
        #2;
        iRSTn = 1'b0;
        #1;
        chk("arst_out",    {22'd0, oOUT}, 32'd0);
        chk("arst_idx",    {28'd0, oIDX}, 32'd0);
        chk("arst_valid",  {31'd0, oVALID}, 32'd0);
        chk("arst_err",    {31'd0, oERR}, 32'd0);
        chk("arst_ready",  {31'd0, oREADY}, 32'd0);
        chk("arst_errcnt", {24'd0, oERR_CNT}, 32'd0);
        sb.delete();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
